pulse_train_tx: RTL and testbench

PULSE_TRAIN_TX -- requirements
Module: pulse_train_tx

---
 rtl/pulse_train_pkg.sv | 11 +
 rtl/pulse_train_cnt.sv | 22 ++
 rtl/pulse_train_tx.sv | 72 +++++++
 tb/tb_pulse_train_tx.sv | 105 ++++++++++
 4 files changed

// File: rtl/pulse_train_pkg.sv
// pulse_train_pkg: state encoding and default widths shared by the pulse train transmitter
package pulse_train_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    GAP  = 2'b10,
    DONE = 2'b11
  } state_t;
  localparam int CNT_W_DEF = 4;
  localparam int GAP_W_DEF = 4;
endpackage

// File: rtl/pulse_train_cnt.sv
// pulse_train_cnt: loadable saturating down-counter with zero and one flags
module pulse_train_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o,
  output logic         one_o
);
  logic [W-1:0] cnt_q, cnt_d;
  // load wins over decrement; decrement stops at zero so the count never wraps
  always_comb cnt_d = load_i ? val_i : (dec_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  // count register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero_o = cnt_q == '0;
  assign one_o  = cnt_q == W'(1);
endmodule

// File: rtl/pulse_train_tx.sv
// pulse_train_tx: Moore FSM emitting n one-cycle pulses separated by max(gap_len,1) low cycles
module pulse_train_tx
  import pulse_train_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_pulses,
  input  logic [GAP_W-1:0] gap_len,
  output logic             ready,
  output logic             busy,
  output logic             x,
  output logic             done
);
  state_t state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic pc_load, pc_zero, pc_one, pc_last;
  logic gc_load, gc_zero, gc_one, gc_last;
  assign pc_load = state_q == IDLE && start && n_pulses != '0;
  assign pc_last = pc_one || pc_zero;
  assign gc_load = state_q == HIGH && !pc_last;
  assign gc_last = gc_one || gc_zero;
  assign gap_d   = pc_load ? (gap_len == '0 ? GAP_W'(1) : gap_len) : gap_q;
  pulse_train_cnt #(.W(CNT_W)) u_pulse_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (pc_load),
    .dec_i  (state_q == HIGH),
    .val_i  (n_pulses),
    .zero_o (pc_zero),
    .one_o  (pc_one)
  );
  pulse_train_cnt #(.W(GAP_W)) u_gap_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (gc_load),
    .dec_i  (state_q == GAP),
    .val_i  (gap_q),
    .zero_o (gc_zero),
    .one_o  (gc_one)
  );
  // state and effective-gap registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  // next state; the zero flags guard against leaving HIGH/GAP on a stale count
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = start ? (n_pulses != '0 ? HIGH : DONE) : IDLE;
      HIGH:    state_d = pc_last ? DONE : GAP;
      GAP:     state_d = gc_last ? HIGH : GAP;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // outputs decoded from the registered state only
  always_comb begin
    ready = state_q == IDLE;
    busy  = state_q == HIGH || state_q == GAP;
    x     = state_q == HIGH;
    done  = state_q == DONE;
  end
endmodule

// File: tb/tb_pulse_train_tx.sv
// tb_pulse_train_tx: random and directed pulse trains checked against a per-cycle expected waveform
module tb_pulse_train_tx;
  localparam int CNT_W = 4;
  localparam int GAP_W = 4;
  localparam logic [3:0] E_HIGH = 4'b1001, E_GAP = 4'b0001, E_DONE = 4'b0100, E_IDLE = 4'b0010;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [CNT_W-1:0] n_pulses = '0;
  logic [GAP_W-1:0] gap_len = '0;
  logic ready, busy, x, done;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  pulse_train_tx #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .n_pulses (n_pulses),
    .gap_len  (gap_len),
    .ready    (ready),
    .busy     (busy),
    .x        (x),
    .done     (done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {x,done,ready,busy}=%b expected %b", tag, got[3:0], exp[3:0]);
    end
  endtask
  function automatic logic [3:0] obs();
    return {x, done, ready, busy};
  endfunction
  task automatic run_train(input int n, input int g, input bit noise, input int repulse);
    logic [3:0] exp_q[$];
    int eg;
    eg = (g == 0) ? 1 : g;
    if (n == 0) exp_q.push_back(E_DONE);
    else begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(E_HIGH);
        if (i < n - 1) for (int j = 0; j < eg; j++) exp_q.push_back(E_GAP);
      end
      exp_q.push_back(E_DONE);
    end
    exp_q.push_back(E_IDLE);
    @(negedge clk);
    start = 1'b1;
    n_pulses = CNT_W'(n);
    gap_len = GAP_W'(g);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      check($sformatf("n%0d_g%0d_c%0d", n, g, k + 1), {28'd0, obs()}, {28'd0, exp_q[k]});
      start = (noise && k < exp_q.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      n_pulses = CNT_W'($urandom);
      gap_len = GAP_W'($urandom);
      if (k + 1 == repulse) begin
        start = 1'b1;
        n_pulses = CNT_W'(1);
      end
    end
    start = 1'b0;
  endtask
  initial begin
    #1 check("reset_state", {28'd0, obs()}, {28'd0, E_IDLE});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_train(3, 2, 1'b0, 0);
    run_train(0, 5, 1'b0, 0);
    run_train(2, 0, 1'b0, 0);
    run_train(4, 1, 1'b0, 3);
    run_train(15, 15, 1'b0, 0);
    @(negedge clk);
    start = 1'b1;
    n_pulses = 3;
    gap_len = 1;
    @(negedge clk);
    start = 1'b0;
    check("abort_c1", {28'd0, obs()}, {28'd0, E_HIGH});
    @(negedge clk);
    check("abort_c2", {28'd0, obs()}, {28'd0, E_GAP});
    @(negedge clk);
    check("abort_c3", {28'd0, obs()}, {28'd0, E_HIGH});
    rst = 1'b1;
    #1 check("abort_now", {28'd0, obs()}, {28'd0, E_IDLE});
    @(negedge clk);
    check("abort_hold", {28'd0, obs()}, {28'd0, E_IDLE});
    rst = 1'b0;
    start = 1'b1;
    n_pulses = 1;
    gap_len = 0;
    @(negedge clk);
    start = 1'b0;
    check("post_rst_c1", {28'd0, obs()}, {28'd0, E_HIGH});
    @(negedge clk);
    check("post_rst_c2", {28'd0, obs()}, {28'd0, E_DONE});
    @(negedge clk);
    check("post_rst_c3", {28'd0, obs()}, {28'd0, E_IDLE});
    repeat (20) run_train($urandom_range(0, 15), $urandom_range(0, 15), 1'b1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
